hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port memread_s3  in  1  EX-stage instruction is a load (MEM-control read bit latched into EX).
REQ-004 SHALL have port rt_addr_s3  in  5  EX-stage load destination register (forward copy of rt).
REQ-005 SHALL have port rs_addr_s2  in  5  ID-stage source register rs.
REQ-006 SHALL have port rt_addr_s2  in  5  ID-stage source register rt.
REQ-007 SHALL have port uses_rt_s2  in  1  ID-stage instruction reads rt as a source.
REQ-008 SHALL have port branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-009 SHALL have port jump_s2  in  1  jump decoded in ID this cycle.
REQ-010 SHALL have port pc_write  out  1  PC register load enable.
REQ-011 SHALL have port ifid_write  out  1  IF/ID register load enable.
REQ-012 SHALL have port ifid_flush  out  1  IF/ID loads a NOP.
REQ-013 SHALL have port idex_bubble  out  1  ID/EX loads all-zero control (bubble).
REQ-014 SHALL have port state  out  2  current FSM state: RUN=0, STALL=1, FLUSH=2.
REQ-015 SHALL have ports stall_cnt, flush_cnt  out  16 each  event counters (see Configuration).

Function
REQ-016 SHALL implement a registered 3-state FSM (RUN, STALL, FLUSH); outputs are combinational (Mealy) from state and inputs.
REQ-017 SHALL define hazard = memread_s3 & (rt_addr_s3!=0) & ((rt_addr_s3==rs_addr_s2) | (uses_rt_s2 & rt_addr_s3==rt_addr_s2)).
REQ-018 SHALL apply priority branch_taken > hazard > jump_s2, evaluated in every state.
REQ-019 SHALL, on branch_taken, drive pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1; next state FLUSH.
REQ-020 SHALL, on hazard in RUN without branch_taken, drive pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1; next state STALL.
REQ-021 SHALL, on jump_s2 in RUN without branch_taken or hazard, drive pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=0; next state RUN.
REQ-022 SHALL, in RUN with no event, drive pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0; stay RUN.
REQ-023 SHALL ignore hazard in STALL and FLUSH (EX holds a bubble), so exactly one bubble per load-use pair; jump_s2 is honoured per REQ-021 in those states.
REQ-024 SHALL leave STALL and FLUSH after exactly one cycle to RUN unless branch_taken forces FLUSH.
REQ-025 SHALL, when branch_taken and hazard coincide, perform the flush only (no stall).
REQ-026 SHALL never assert pc_write=0 for more than one consecutive cycle.

Reset
REQ-027 SHALL, while rst_n=0, force state=RUN, pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, counters=0, independent of clk.
REQ-028 SHALL, on rst_n deassertion, resume in RUN at the next clk edge; reset mid-STALL discards the pending stall.

Configuration
REQ-029 SHALL, with HAZARD_STATS_EN defined, increment stall_cnt on each cycle entering STALL and flush_cnt on each cycle asserting ifid_flush (branch or jump), both saturating at 16'hFFFF.
REQ-030 SHALL, without HAZARD_STATS_EN, tie stall_cnt and flush_cnt to 0 with no counter flops; FSM behaviour identical.

Verification
REQ-031 SHALL test load-use: memread_s3=1, rt_addr_s3=8, rs_addr_s2=8 in RUN -> pc_write=0, ifid_write=0, idex_bubble=1 one cycle, then STALL with all enables 1, then RUN.
REQ-032 SHALL test rt gating: rt_addr_s3=9, rt_addr_s2=9, uses_rt_s2=0 -> no stall; uses_rt_s2=1 -> stall; rt_addr_s3=0 -> never stall.
REQ-033 SHALL test branch: branch_taken=1 with simultaneous hazard -> ifid_flush=1, idex_bubble=1, pc_write=1, next state=2, stall_cnt unchanged.
REQ-034 SHALL test jump: jump_s2=1 in RUN -> ifid_flush=1, idex_bubble=0, state stays 0; with HAZARD_STATS_EN flush_cnt +1.
REQ-035 SHALL test reset: rst_n=0 asserted mid-STALL -> state=0, pc_write=0, idex_bubble=1 immediately, counters=0.
REQ-036 SHALL test saturation: with HAZARD_STATS_EN, 65540 load-use events -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller. Detects load-use hazards between
//               the EX-stage load and the ID-stage sources, and handles taken
//               branches and jumps. Branch flush beats load-use stall, which
//               beats jump flush. A stall inserts exactly one bubble.
//               Optional event counters are built when HAZARD_STATS_EN is
//               defined; otherwise stall_cnt/flush_cnt are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memread_s3,
  input  logic [4:0]  rt_addr_s3,
  input  logic [4:0]  rs_addr_s2,
  input  logic [4:0]  rt_addr_s2,
  input  logic        uses_rt_s2,
  input  logic        branch_taken,
  input  logic        jump_s2,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   hazard;

  // Load in EX writes a register that the ID instruction reads; r0 never hazards
  assign hazard = memread_s3 && (rt_addr_s3 != 5'd0) &&
                  ((rt_addr_s3 == rs_addr_s2) ||
                   (uses_rt_s2 && (rt_addr_s3 == rt_addr_s2)));

  // Next-state and Mealy outputs; hazard only honoured in RUN since EX holds a bubble otherwise
  always_comb begin
    state_d     = RUN;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = RUN;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = FLUSH;
    end else if (hazard && (state_q == RUN)) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_d     = STALL;
    end else if (jump_s2) begin
      ifid_flush  = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;
  logic [15:0] flush_cnt_q;
  logic [15:0] flush_cnt_d;

  // Saturating event counters: stall entries and IF/ID flush cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (rst_n && (state_d == STALL) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (rst_n && ifid_flush && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 16'd0;
  assign flush_cnt = 16'd0;
`endif

endmodule
`default_nettype wire
